// File: rtl/instr_compressor_if.sv
// Stream interface of the instruction compressor.
//   CPU side  : in_valid/in_ready handshake carrying in_instr plus the
//               in_branch (start a fresh output word) and in_flush
//               (push out a half-filled word) qualifiers.
//   Memory side: out_valid/out_ready handshake carrying out_word and
//               out_encode (1 = two halfword slots, 0 = raw instruction).
// master = the agent driving the CPU side and consuming output words.
// slave  = the compressor itself.
interface instr_compressor_if #(
    parameter int IW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_instr;
    logic          in_branch;
    logic          in_flush;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_word;
    logic          out_encode;

    modport master (
        output in_valid, in_instr, in_branch, in_flush, out_ready,
        input  in_ready, out_valid, out_word, out_encode
    );

    modport slave (
        input  in_valid, in_instr, in_branch, in_flush, out_ready,
        output in_ready, out_valid, out_word, out_encode
    );
endinterface

// File: rtl/instr_compressor.sv
// Dictionary-based instruction compressor.
// Instructions found in a small dictionary are replaced by a 16-bit
// halfword {1, 0..0, idx}; two such halfwords are packed per output word.
// Misses pass through as raw words. A branch target or a miss arriving
// while one halfword is held forces the held halfword out padded with
// 16'h0000, and the new instruction waits one cycle in a pending register.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   dict_we/addr/data  dictionary write port (entry becomes valid)
//   bus                stream interface (slave modport)
//   hit_count          saturating count of compressed halfwords emitted
module instr_compressor #(
    parameter int DICT_DEPTH = 16,
    parameter int IW         = 32,
    parameter int IDXW       = $clog2(DICT_DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dict_we,
    input  logic [IDXW-1:0]     dict_addr,
    input  logic [IW-1:0]       dict_data,
    instr_compressor_if.slave   bus,
    output logic [15:0]         hit_count
);
    typedef enum logic [1:0] {EMPTY, HALF, PEND} state_t;

    // ---------------- dictionary ----------------
    logic [IW-1:0]         dict_entry_q [DICT_DEPTH];
    logic [IW-1:0]         dict_entry_d [DICT_DEPTH];
    logic [DICT_DEPTH-1:0] dict_valid_q, dict_valid_d;
    logic [DICT_DEPTH-1:0] match;

    genvar gi;
    generate
        for (gi = 0; gi < DICT_DEPTH; gi++) begin : g_dict
            logic entry_we;
            assign entry_we = dict_we && (dict_addr == IDXW'(gi));
            // Lookup uses the registered contents, so a same-cycle write
            // is only seen from the following cycle.
            assign match[gi] = dict_valid_q[gi] && (dict_entry_q[gi] == bus.in_instr);

            always_comb begin
                dict_valid_d[gi] = dict_valid_q[gi] | entry_we;
                dict_entry_d[gi] = entry_we ? dict_data : dict_entry_q[gi];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dict_valid_q[gi] <= 1'b0;
                    dict_entry_q[gi] <= '0;
                end else begin
                    dict_valid_q[gi] <= dict_valid_d[gi];
                    dict_entry_q[gi] <= dict_entry_d[gi];
                end
            end
        end
    endgenerate

    // Lowest matching index wins: scan downward so lower indices overwrite.
    logic            lk_hit;
    logic [IDXW-1:0] lk_idx;
    always_comb begin
        lk_hit = 1'b0;
        lk_idx = '0;
        for (int i = DICT_DEPTH - 1; i >= 0; i--) begin
            if (match[i]) begin
                lk_hit = 1'b1;
                lk_idx = IDXW'(i);
            end
        end
    end

    function automatic logic [15:0] make_hw(input logic [IDXW-1:0] idx);
        return {1'b1, {(15 - IDXW){1'b0}}, idx};
    endfunction

    // ---------------- packing state ----------------
    state_t          state_q, state_d;
    logic [15:0]     held_q, held_d;
    logic [IW-1:0]   pend_instr_q, pend_instr_d;
    logic            pend_hit_q, pend_hit_d;
    logic [IDXW-1:0] pend_idx_q, pend_idx_d;
    logic            out_valid_q, out_valid_d;
    logic [IW-1:0]   out_word_q, out_word_d;
    logic            out_encode_q, out_encode_d;
    logic [15:0]     hit_count_q, hit_count_d;

    logic       out_free;
    logic       accept;
    logic [1:0] hit_inc;
    logic [16:0] hit_sum;

    assign out_free = !out_valid_q || bus.out_ready;
    assign bus.in_ready = out_free && (state_q != PEND);
    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d      = state_q;
        held_d       = held_q;
        pend_instr_d = pend_instr_q;
        pend_hit_d   = pend_hit_q;
        pend_idx_d   = pend_idx_q;
        out_valid_d  = out_valid_q && !bus.out_ready;
        out_word_d   = out_word_q;
        out_encode_d = out_encode_q;
        hit_inc      = 2'd0;

        case (state_q)
            EMPTY: begin
                // Already word-aligned, so in_branch needs no action here.
                if (accept) begin
                    if (lk_hit) begin
                        held_d  = make_hw(lk_idx);
                        state_d = HALF;
                    end else begin
                        out_valid_d  = 1'b1;
                        out_word_d   = bus.in_instr;
                        out_encode_d = 1'b0;
                    end
                end
            end
            HALF: begin
                if (accept) begin
                    out_valid_d  = 1'b1;
                    out_encode_d = 1'b1;
                    held_d       = '0;
                    if (lk_hit && !bus.in_branch) begin
                        out_word_d = IW'({make_hw(lk_idx), held_q});
                        hit_inc    = 2'd2;
                        state_d    = EMPTY;
                    end else begin
                        out_word_d   = IW'({16'h0000, held_q});
                        hit_inc      = 2'd1;
                        pend_instr_d = bus.in_instr;
                        pend_hit_d   = lk_hit;
                        pend_idx_d   = lk_idx;
                        state_d      = PEND;
                    end
                end else if (bus.in_flush && out_free) begin
                    out_valid_d  = 1'b1;
                    out_encode_d = 1'b1;
                    out_word_d   = IW'({16'h0000, held_q});
                    hit_inc      = 2'd1;
                    held_d       = '0;
                    state_d      = EMPTY;
                end
            end
            PEND: begin
                if (out_free) begin
                    if (pend_hit_q) begin
                        held_d  = make_hw(pend_idx_q);
                        state_d = HALF;
                    end else begin
                        out_valid_d  = 1'b1;
                        out_word_d   = pend_instr_q;
                        out_encode_d = 1'b0;
                        state_d      = EMPTY;
                    end
                    pend_instr_d = '0;
                    pend_hit_d   = 1'b0;
                    pend_idx_d   = '0;
                end
            end
            default: state_d = EMPTY;
        endcase

        hit_sum     = {1'b0, hit_count_q} + 17'(hit_inc);
        hit_count_d = hit_sum[16] ? 16'hFFFF : hit_sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            held_q       <= '0;
            pend_instr_q <= '0;
            pend_hit_q   <= 1'b0;
            pend_idx_q   <= '0;
            out_valid_q  <= 1'b0;
            out_word_q   <= '0;
            out_encode_q <= 1'b0;
            hit_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            held_q       <= held_d;
            pend_instr_q <= pend_instr_d;
            pend_hit_q   <= pend_hit_d;
            pend_idx_q   <= pend_idx_d;
            out_valid_q  <= out_valid_d;
            out_word_q   <= out_word_d;
            out_encode_q <= out_encode_d;
            hit_count_q  <= hit_count_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_word   = out_word_q;
    assign bus.out_encode = out_encode_q;
    assign hit_count      = hit_count_q;
endmodule

// File: tb/tb_instr_compressor.sv
module tb_instr_compressor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        dict_we;
    logic [3:0]  dict_addr;
    logic [31:0] dict_data;
    logic [15:0] hit_count;
    int          tests = 0;
    int          fails = 0;

    instr_compressor_if #(.IW(32)) bus ();

    instr_compressor #(.DICT_DEPTH(16), .IW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dict_we   (dict_we),
        .dict_addr (dict_addr),
        .dict_data (dict_data),
        .bus       (bus.slave),
        .hit_count (hit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] w, input logic e);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        if (v) begin
            check({tag, ".word"}, bus.out_word, w);
            check({tag, ".encode"}, 32'(bus.out_encode), 32'(e));
        end
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_branch = 1'b0;
        bus.in_flush  = 1'b0;
        dict_we       = 1'b0;
    endtask

    // Offer one instruction at the current falling edge; returns at the next
    // falling edge with the stimulus removed.
    task automatic send(input logic [31:0] instr, input logic branch);
        bus.in_valid  = 1'b1;
        bus.in_instr  = instr;
        bus.in_branch = branch;
        @(negedge clk);
        idle();
    endtask

    task automatic dict_write(input logic [3:0] a, input logic [31:0] d);
        dict_we   = 1'b1;
        dict_addr = a;
        dict_data = d;
        @(negedge clk);
        dict_we   = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        dict_addr     = '0;
        dict_data     = '0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b1;
        idle();
        @(negedge clk);
        // Reset state
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.out_word", bus.out_word, 32'd0);
        check("rst.out_encode", 32'(bus.out_encode), 32'd0);
        check("rst.hit_count", 32'(hit_count), 32'd0);
        check("rst.in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        $display("[TB] reset checked");

        // Raw pass-through with empty dictionary, latency 1
        send(32'hDEADBEEF, 1'b0);
        check_out("raw", 1'b1, 32'hDEADBEEF, 1'b0);
        check("raw.hit_count", 32'(hit_count), 32'd0);
        @(negedge clk);
        check_out("raw.drain", 1'b0, 32'h0, 1'b0);
        $display("[TB] raw DEADBEEF checked");

        // Two hits packed into one word
        dict_write(4'd3, 32'h00000013);
        send(32'h00000013, 1'b0);
        check_out("pair.first", 1'b0, 32'h0, 1'b0);
        send(32'h00000013, 1'b0);
        check_out("pair", 1'b1, 32'h80038003, 1'b1);
        check("pair.hit_count", 32'(hit_count), 32'd2);
        @(negedge clk);
        check_out("pair.drain", 1'b0, 32'h0, 1'b0);
        $display("[TB] pair 80038003 checked");

        // Hit then miss: padded word, in_ready low in PEND, then raw
        send(32'h00000013, 1'b0);
        send(32'hDEADBEEF, 1'b0);
        check_out("miss.pad", 1'b1, 32'h00008003, 1'b1);
        check("miss.in_ready_pend", 32'(bus.in_ready), 32'd0);
        check("miss.hit_count", 32'(hit_count), 32'd3);
        @(negedge clk);
        check_out("miss.raw", 1'b1, 32'hDEADBEEF, 1'b0);
        check("miss.in_ready_after", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        check_out("miss.drain", 1'b0, 32'h0, 1'b0);
        $display("[TB] hit+miss checked");

        // Hit, hit-as-branch-target, flush
        send(32'h00000013, 1'b0);
        send(32'h00000013, 1'b1);
        check_out("branch.pad", 1'b1, 32'h00008003, 1'b1);
        check("branch.hit_count", 32'(hit_count), 32'd4);
        @(negedge clk);
        check_out("branch.pend_to_half", 1'b0, 32'h0, 1'b0);
        bus.in_flush = 1'b1;
        @(negedge clk);
        bus.in_flush = 1'b0;
        check_out("flush", 1'b1, 32'h00008003, 1'b1);
        check("flush.hit_count", 32'(hit_count), 32'd5);
        // Flush in EMPTY does nothing
        bus.in_flush = 1'b1;
        @(negedge clk);
        bus.in_flush = 1'b0;
        check_out("flush.empty", 1'b0, 32'h0, 1'b0);
        check("flush.empty.hit_count", 32'(hit_count), 32'd5);
        $display("[TB] branch+flush checked");

        // Backpressure: output held stable, new offer refused
        bus.out_ready = 1'b0;
        send(32'h12345678, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_instr = 32'hCAFEF00D;
        for (int i = 0; i < 5; i++) begin
            check_out("stall", 1'b1, 32'h12345678, 1'b0);
            check("stall.in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        idle();
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_out("stall.consumed", 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check_out("stall.once", 1'b0, 32'h0, 1'b0);
        $display("[TB] backpressure checked");

        // Reset while HALF discards the held halfword and dictionary
        send(32'h00000013, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst.out_valid", 32'(bus.out_valid), 32'd0);
        check("arst.hit_count", 32'(hit_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(32'h00000013, 1'b0);
        check_out("arst.raw", 1'b1, 32'h00000013, 1'b0);
        bus.in_flush = 1'b1;
        @(negedge clk);
        bus.in_flush = 1'b0;
        check_out("arst.nothing_held", 1'b0, 32'h0, 1'b0);
        $display("[TB] mid-operation reset checked");

        // Same-cycle write and lookup sees old contents
        dict_we      = 1'b1;
        dict_addr    = 4'd7;
        dict_data    = 32'hAAAA0000;
        bus.in_valid = 1'b1;
        bus.in_instr = 32'hAAAA0000;
        @(negedge clk);
        idle();
        check_out("wr_lookup", 1'b1, 32'hAAAA0000, 1'b0);
        $display("[TB] write/lookup ordering checked");

        // Lowest matching index wins
        dict_write(4'd5, 32'h00000013);
        dict_write(4'd2, 32'h00000013);
        send(32'h00000013, 1'b0);
        send(32'h00000013, 1'b0);
        check_out("lowidx", 1'b1, 32'h80028002, 1'b1);
        check("lowidx.hit_count", 32'(hit_count), 32'd2);
        $display("[TB] lowest index checked");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instr_compressor.md
INSTR_COMPRESSOR -- requirements
Module: instr_compressor

Interface
REQ-001 SHALL have parameter DICT_DEPTH, default 16, meaning number of dictionary entries (index width IDXW = log2(DICT_DEPTH) = 4).
REQ-002 SHALL have parameter IW, default 32, meaning instruction width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 dict_we  input  1  dictionary write strobe.
REQ-006 dict_addr  input  IDXW  dictionary write index.
REQ-007 dict_data  input  IW  dictionary entry value; written entry becomes valid.
REQ-008 in_valid  input  1  CPU-side instruction offered.
REQ-009 in_ready  output  1  compressor accepts in_instr this cycle.
REQ-010 in_instr  input  IW  uncompressed instruction.
REQ-011 in_branch  input  1  accepted instruction is a branch target and must start a new output word.
REQ-012 in_flush  input  1  force out a half-filled word.
REQ-013 out_valid  output  1  out_word valid toward memory/decompressor side.
REQ-014 out_ready  input  1  downstream accepts out_word.
REQ-015 out_word  output  IW  packed word.
REQ-016 out_encode  output  1  1 = out_word holds compressed halfwords; 0 = raw instruction.
REQ-017 hit_count  output  16  number of compressed instructions emitted, saturating.

Function
REQ-018 Lookup SHALL compare in_instr against all valid entries combinationally; lowest matching index wins; no valid match = raw.
REQ-019 Dictionary write and lookup in same cycle SHALL see pre-write contents; write visible from next cycle.
REQ-020 Compressed halfword SHALL be {1'b1, 11'b0, idx}; pad halfword SHALL be 16'h0000.
REQ-021 Compressed word SHALL place first halfword in [15:0], second in [31:16].
REQ-022 States: EMPTY (no held half), HALF (one compressed halfword held), PEND (padded word issued, accepted instruction stashed in pending register).
REQ-023 Output register SHALL be free when !out_valid or out_ready; out_word/out_encode SHALL stay stable while out_valid & !out_ready.
REQ-024 in_ready SHALL = output register free AND state != PEND.
REQ-025 EMPTY, accept raw: out_word = in_instr, out_encode=0, out_valid next cycle (latency 1); stay EMPTY.
REQ-026 EMPTY, accept compressed: hold halfword, go HALF, no output.
REQ-027 HALF, accept compressed, in_branch=0: emit {new, held}, out_encode=1, go EMPTY.
REQ-028 HALF, accept raw or in_branch=1: emit {16'h0000, held}, out_encode=1, stash instruction and its lookup result, go PEND.
REQ-029 PEND, output free: process stash as in EMPTY (raw -> emit, go EMPTY; compressed -> go HALF with no output).
REQ-030 HALF, in_flush=1, no instruction accepted, output free: emit {16'h0000, held}, go EMPTY.
REQ-031 in_flush in EMPTY or PEND SHALL have no effect; in_flush with a simultaneous accept SHALL be ignored that cycle.
REQ-032 in_branch in EMPTY SHALL behave as REQ-025/026 (word already aligned).
REQ-033 hit_count SHALL increment by 1 per compressed halfword (not pad) entering an emitted word, by 2 when two enter together, saturating at 16'hFFFF.

Reset
REQ-034 reset low SHALL asynchronously clear: state EMPTY, all dictionary valid bits 0, out_valid 0, out_word 0, out_encode 0, hit_count 0, held/pending registers 0; in_ready = 1 after release.
REQ-035 Reset mid-operation SHALL discard held halfword and pending instruction without emitting them.

Verification
REQ-036 Load entry 3 = 32'h00000013; send 32'h00000013 twice, out_ready=1 -> one word 32'h80038003, out_encode=1, hit_count=2.
REQ-037 Empty dictionary; send 32'hDEADBEEF -> next cycle out_word 32'hDEADBEEF, out_encode=0, hit_count=0.
REQ-038 Entry 3 loaded; send 32'h00000013 then 32'hDEADBEEF -> 32'h00008003 (encode=1) then 32'hDEADBEEF (encode=0); in_ready low in PEND cycle.
REQ-039 Entry 3 loaded; send 32'h00000013, then 32'h00000013 with in_branch=1, then in_flush -> 32'h00008003, then 32'h00008003.
REQ-040 Hold out_ready=0 with out_valid=1 for 5 cycles -> out_word stable, in_ready=0; release -> word consumed once.
REQ-041 Assert reset low while HALF -> out_valid=0, hit_count=0, dictionary empty; 32'h00000013 afterwards emits raw.
